// File: rtl/snn_timestep_scheduler.sv
// Timestep sequencer for the two-layer spiking network.
// Ports: clk/reset; start/num_steps run control; in_spikes/in_valid/in_ready
// input handshake; net_* drive and observe the network; busy/step_index
// progress; spike_counts/winner/no_spikes result with out_valid/out_ready.
module snn_timestep_scheduler #(
    parameter int M1      = 8,
    parameter int N2      = 8,
    parameter int CNT_W   = 8,
    parameter int STEPS_W = 8,
    localparam int WIN_W  = (N2 > 1) ? $clog2(N2) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [STEPS_W-1:0]    num_steps,
    input  logic [M1-1:0]         in_spikes,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  net_enable,
    output logic                  net_delay_clk,
    output logic [M1-1:0]         net_input_spikes,
    input  logic [N2-1:0]         net_output_spikes,
    input  logic                  net_data_ready,
    output logic                  busy,
    output logic [STEPS_W-1:0]    step_index,
    output logic [N2*CNT_W-1:0]   spike_counts,
    output logic [WIN_W-1:0]      winner,
    output logic                  no_spikes,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT,
        S_TICK,
        S_DONE
    } state_t;

    state_t             state;
    logic [STEPS_W-1:0] steps_lat;

    // Argmax over the settled counts; strict '>' keeps the lowest index on ties.
    logic [CNT_W-1:0]   best_cnt;
    logic [WIN_W-1:0]   best_idx;

    always_comb begin
        best_cnt = '0;
        best_idx = '0;
        for (int i = 0; i < N2; i++) begin
            if (spike_counts[i*CNT_W +: CNT_W] > best_cnt) begin
                best_cnt = spike_counts[i*CNT_W +: CNT_W];
                best_idx = WIN_W'(i);
            end
        end
    end

    logic last_step;
    assign last_step = (step_index == steps_lat - STEPS_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            steps_lat        <= '0;
            in_ready         <= 1'b0;
            net_enable       <= 1'b0;
            net_delay_clk    <= 1'b0;
            net_input_spikes <= '0;
            busy             <= 1'b0;
            step_index       <= '0;
            spike_counts     <= '0;
            winner           <= '0;
            no_spikes        <= 1'b0;
            out_valid        <= 1'b0;
        end else begin
            // Both network strobes are single-cycle pulses.
            net_enable    <= 1'b0;
            net_delay_clk <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && num_steps != '0) begin
                        steps_lat    <= num_steps;
                        spike_counts <= '0;
                        step_index   <= '0;
                        winner       <= '0;
                        no_spikes    <= 1'b0;
                        busy         <= 1'b1;
                        in_ready     <= 1'b1;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        net_input_spikes <= in_spikes;
                        in_ready         <= 1'b0;
                        net_enable       <= 1'b1;
                        state            <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (net_data_ready) begin
                        for (int i = 0; i < N2; i++) begin
                            if (net_output_spikes[i] &&
                                spike_counts[i*CNT_W +: CNT_W] != '1) begin
                                spike_counts[i*CNT_W +: CNT_W] <=
                                    spike_counts[i*CNT_W +: CNT_W] + CNT_W'(1);
                            end
                        end
                        net_delay_clk <= 1'b1;
                        state         <= S_TICK;
                    end
                end
                S_TICK: begin
                    if (last_step) begin
                        winner    <= best_idx;
                        no_spikes <= (best_cnt == '0);
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        step_index <= step_index + STEPS_W'(1);
                        in_ready   <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Self-checking bench for snn_timestep_scheduler.
// Directed and random runs scored against a per-run spike count model.
module tb_snn_timestep_scheduler;

    localparam int M1      = 8;
    localparam int N2      = 8;
    localparam int CNT_W   = 2;
    localparam int STEPS_W = 8;
    localparam int WIN_W   = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [STEPS_W-1:0]  num_steps = '0;
    logic [M1-1:0]       in_spikes = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                net_enable;
    logic                net_delay_clk;
    logic [M1-1:0]       net_input_spikes;
    logic [N2-1:0]       net_output_spikes = '0;
    logic                net_data_ready = 1'b0;
    logic                busy;
    logic [STEPS_W-1:0]  step_index;
    logic [N2*CNT_W-1:0] spike_counts;
    logic [WIN_W-1:0]    winner;
    logic                no_spikes;
    logic                out_valid;
    logic                out_ready = 1'b0;

    snn_timestep_scheduler #(
        .M1(M1), .N2(N2), .CNT_W(CNT_W), .STEPS_W(STEPS_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_steps(num_steps),
        .in_spikes(in_spikes), .in_valid(in_valid), .in_ready(in_ready),
        .net_enable(net_enable), .net_delay_clk(net_delay_clk),
        .net_input_spikes(net_input_spikes),
        .net_output_spikes(net_output_spikes),
        .net_data_ready(net_data_ready), .busy(busy),
        .step_index(step_index), .spike_counts(spike_counts),
        .winner(winner), .no_spikes(no_spikes),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_pulses = 0;
    int tk_pulses = 0;

    always @(posedge clk) begin
        cyc++;
        if (net_enable) en_pulses++;
        if (net_delay_clk) tk_pulses++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference: per-neuron totals of spikes seen this run, clipped at CMAX.
    int mcnt [N2];
    logic [N2-1:0] vq [$];

    function automatic logic [N2*CNT_W-1:0] model_counts();
        logic [N2*CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < N2; i++) r[i*CNT_W +: CNT_W] = CNT_W'(mcnt[i]);
        return r;
    endfunction

    function automatic int model_max();
        int mx = 0;
        for (int i = 0; i < N2; i++) if (mcnt[i] > mx) mx = mcnt[i];
        return mx;
    endfunction

    function automatic int model_winner();
        int mx = model_max();
        for (int i = 0; i < N2; i++) if (mcnt[i] == mx) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input int n, input int dly, input int stall_step,
                          input int abort_step, input bit busy_start,
                          input int hold);
        int t0;
        int lat;
        int e0;
        int k0;
        int d;
        logic [M1-1:0] v;
        logic [N2-1:0] o;
        v = '0;
        for (int i = 0; i < N2; i++) mcnt[i] = 0;
        lat = 0;
        e0 = en_pulses;
        k0 = tk_pulses;
        start = 1'b1;
        num_steps = STEPS_W'(n);
        tick();
        start = 1'b0;
        t0 = cyc;
        chk("busy_start", busy, 1);
        chk("in_ready_load", in_ready, 1);
        chk("counts_cleared", spike_counts, 0);
        for (int s = 0; s < n; s++) begin
            d = (dly != 0) ? dly : int'($urandom_range(1, 3));
            if (s > 0) chk("vec_held", net_input_spikes, v);
            if (s == stall_step) begin
                repeat (10) begin
                    tick();
                    chk("stall_no_en", net_enable, 0);
                    chk("stall_step", step_index, s);
                    lat++;
                end
            end
            v = M1'($urandom);
            o = (vq.size() != 0) ? vq.pop_front() : N2'($urandom);
            in_spikes = v;
            in_valid = 1'b1;
            if (busy_start && s == 0) begin
                start = 1'b1;
                num_steps = 8'd5;
            end
            tick();
            in_valid = 1'b0;
            in_spikes = M1'($urandom);
            start = 1'b0;
            chk("enable_pulse", net_enable, 1);
            chk("net_vec", net_input_spikes, v);
            chk("step_index", step_index, s);
            chk("in_ready_low", in_ready, 0);
            if (s == abort_step) begin
                tick();
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_en", net_enable, 0);
                chk("abort_valid", out_valid, 0);
                chk("abort_counts", spike_counts, 0);
                chk("abort_step", step_index, 0);
                chk("abort_in_ready", in_ready, 0);
                tick();
                chk("abort_idle", busy, 0);
                return;
            end
            for (int j = 0; j < d; j++) begin
                if (j == 0 && $urandom_range(0, 1) == 1) begin
                    net_data_ready = 1'b1;
                    net_output_spikes = N2'($urandom);
                end
                tick();
                net_data_ready = 1'b0;
                if (j == 0) chk("enable_once", net_enable, 0);
            end
            net_data_ready = 1'b1;
            net_output_spikes = o;
            tick();
            net_data_ready = 1'b0;
            net_output_spikes = N2'($urandom);
            for (int i = 0; i < N2; i++)
                if (o[i] && mcnt[i] < CMAX) mcnt[i]++;
            chk("delay_clk", net_delay_clk, 1);
            chk("counts_step", spike_counts, model_counts());
            lat += d + 3;
            tick();
            chk("delay_clk_once", net_delay_clk, 0);
            chk("valid_timing", out_valid, (s == n - 1) ? 1 : 0);
        end
        chk("latency", cyc - t0, lat);
        chk("en_pulses", en_pulses - e0, n);
        chk("tick_pulses", tk_pulses - k0, n);
        chk("counts_done", spike_counts, model_counts());
        chk("winner", winner, model_winner());
        chk("no_spikes", no_spikes, (model_max() == 0) ? 1 : 0);
        chk("busy_done", busy, 1);
        for (int j = 0; j < hold; j++) begin
            if (j % 2 == 1) begin
                net_data_ready = 1'b1;
                net_output_spikes = '1;
            end
            tick();
            net_data_ready = 1'b0;
            chk("hold_valid", out_valid, 1);
            chk("hold_counts", spike_counts, model_counts());
            chk("hold_winner", winner, model_winner());
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("idle_busy", busy, 0);
        net_data_ready = 1'b1;
        net_output_spikes = '1;
        tick();
        net_data_ready = 1'b0;
        chk("idle_counts", spike_counts, model_counts());
        chk("idle_winner", winner, model_winner());
        chk("idle_no_en", net_enable, 0);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_en", net_enable, 0);
        chk("rst_dclk", net_delay_clk, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_counts", spike_counts, 0);
        chk("rst_winner", winner, 0);
        chk("rst_nospk", no_spikes, 0);
        chk("rst_step", step_index, 0);
        chk("rst_vec", net_input_spikes, 0);

        vq = '{8'h05, 8'h05, 8'h05};
        do_run(3, 2, -1, -1, 1'b0, 4);

        vq = '{8'h80, 8'hC0};
        do_run(2, 2, -1, -1, 1'b1, 1);

        start = 1'b1;
        num_steps = '0;
        tick();
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("zero_busy", busy, 0);
            chk("zero_in_ready", in_ready, 0);
            chk("zero_no_en", net_enable, 0);
            tick();
        end

        vq = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
        do_run(6, 2, 1, -1, 1'b0, 2);

        vq = '{8'h00, 8'h00};
        do_run(2, 0, -1, -1, 1'b0, 1);

        vq = '{8'h3C, 8'h11};
        do_run(3, 2, -1, 1, 1'b0, 0);

        for (int r = 0; r < 6; r++) begin
            vq.delete();
            do_run(int'($urandom_range(1, 8)), 0, -1, -1, 1'b0,
                   int'($urandom_range(0, 3)));
        end

        vq.delete();
        do_run(255, 1, -1, -1, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
